// File: rtl/exp_update_pipe.sv
// exp_update_pipe: two-stage pipelined exponent update for an IEEE-style adder.
// S1 forms the signed internal exponent from the normalisation/rounding shift
// information, and S2 classifies it into the final biased exponent and flags.
// A valid/ready handshake lets the surrounding FPU pipeline stall.
// Optional build macro EXP_UPDATE_STICKY_EN adds sticky overflow/underflow
// flags with a clear input.
module exp_update_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int SH_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   exp_in,
    input  logic               ovf,
    input  logic               ovf_rnd,
    input  logic [SH_W-1:0]    massive_shift_left,
    input  logic               one_shift_left,
    input  logic [1:0]         sum_msb,
    input  logic               sum_zero,
    input  logic               eop,
    input  logic               zero_d,
    input  logic               frac_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   exp_out,
    output logic               max_exp,
    output logic               min_exp,
    output logic [EXP_W+1:0]   excess_shift,
`ifdef EXP_UPDATE_STICKY_EN
    input  logic               sticky_clr,
    output logic               sticky_ovf,
    output logic               sticky_unf,
`endif
    output logic               underflow
);

    // Internal exponent carries two extra bits: one for headroom above the
    // all-ones code and one for sign (negative means denormal result).
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] OVF_TH = {2'b00, {EXP_W{1'b1}}};

    // The shift count must be able to cover the whole widened sum.
    if (SH_W < $clog2(MAN_W + 4)) begin : g_sh_w_check
        $error("SH_W too narrow for MAN_W");
    end

    // ---------------- Stage 1 state ----------------
    logic          s1_valid;
    logic [EW-1:0] s1_e;
    logic          s1_msb1;
    logic          s1_sum_zero;
    logic          s1_eop;
    logic          s1_zero_d;
    logic          s1_frac_zero;

    // ---------------- Stage 2 state ----------------
    logic          s2_valid;

    logic          s1_ready;
    logic          s2_ready;
    logic [EW-1:0] e_next;

    logic [EXP_W-1:0] c_exp;
    logic             c_max;
    logic             c_min;
    logic [EW-1:0]    c_excess;
    logic             c_unf;

    // A stage may load when it is empty or its content is leaving this cycle.
    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = !rst && s1_ready;
    assign out_valid = s2_valid;

    // Internal exponent: left path undoes the leading-zero shift, otherwise
    // apply carry-out, rounding overflow and the single near-path shift.
    always_comb begin
        e_next = {2'b00, exp_in} + EW'(ovf);
        if ({ovf, sum_msb} == 3'b000) begin
            e_next = e_next - EW'(massive_shift_left);
        end else begin
            e_next = e_next + EW'(ovf_rnd) - EW'(one_shift_left);
        end
    end

    // Stage 1 register: capture the exponent and classification inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_e         <= '0;
            s1_msb1      <= 1'b0;
            s1_sum_zero  <= 1'b0;
            s1_eop       <= 1'b0;
            s1_zero_d    <= 1'b0;
            s1_frac_zero <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_e         <= e_next;
                s1_msb1      <= sum_msb[1];
                s1_sum_zero  <= sum_zero;
                s1_eop       <= eop;
                s1_zero_d    <= zero_d;
                s1_frac_zero <= frac_zero;
            end
        end
    end

    // Classification of the internal exponent, first matching case wins.
    always_comb begin
        c_exp    = s1_e[EXP_W-1:0];
        c_max    = 1'b0;
        c_min    = 1'b0;
        c_excess = '0;
        c_unf    = 1'b0;
        if (s1_sum_zero && s1_eop && s1_zero_d) begin
            // Exact cancellation gives a true zero.
            c_exp = '0;
            c_min = 1'b1;
        end else if (!s1_e[EW-1] && (s1_e >= OVF_TH)) begin
            c_exp = '1;
            c_max = 1'b1;
        end else if (s1_e[EW-1]) begin
            // Below the normal range: denormalise by the magnitude of e.
            c_exp    = '0;
            c_min    = 1'b1;
            c_unf    = 1'b1;
            c_excess = -s1_e;
        end else if (s1_e == '0) begin
            if (s1_msb1) begin
                // Rounding carried into the hidden bit: smallest normal.
                c_exp = {{(EXP_W-1){1'b0}}, 1'b1};
            end else begin
                c_exp = '0;
                c_min = 1'b1;
                c_unf = !s1_frac_zero;
            end
        end
    end

    // Stage 2 register: outputs hold while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            exp_out      <= '0;
            max_exp      <= 1'b0;
            min_exp      <= 1'b0;
            excess_shift <= '0;
            underflow    <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                exp_out      <= c_exp;
                max_exp      <= c_max;
                min_exp      <= c_min;
                excess_shift <= c_excess;
                underflow    <= c_unf;
            end
        end
    end

`ifdef EXP_UPDATE_STICKY_EN
    logic out_xfer;
    assign out_xfer = s2_valid && out_ready;

    // Sticky flags accumulate over delivered results; a new event beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            if (out_xfer && max_exp) begin
                sticky_ovf <= 1'b1;
            end else if (sticky_clr) begin
                sticky_ovf <= 1'b0;
            end
            if (out_xfer && underflow) begin
                sticky_unf <= 1'b1;
            end else if (sticky_clr) begin
                sticky_unf <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_exp_update_pipe.sv
// Testbench for exp_update_pipe: directed vectors, scoreboard queue and a
// decoupled output monitor; a second double-precision instance is checked
// directly (and its sticky overflow flag when EXP_UPDATE_STICKY_EN is set).
module tb_exp_update_pipe;

    typedef struct packed {
        logic [7:0] e;
        logic       mx;
        logic       mn;
        logic [9:0] xs;
        logic       uf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] exp_in = '0;
    logic       ovf = 1'b0;
    logic       ovf_rnd = 1'b0;
    logic [4:0] msl = '0;
    logic       osl = 1'b0;
    logic [1:0] sum_msb = '0;
    logic       sum_zero = 1'b0;
    logic       eop = 1'b0;
    logic       zero_d = 1'b0;
    logic       frac_zero = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] exp_out;
    logic       max_exp;
    logic       min_exp;
    logic [9:0] excess_shift;
    logic       underflow;

    logic        d_in_valid = 1'b0;
    logic        d_in_ready;
    logic [10:0] d_exp_in = '0;
    logic        d_ovf = 1'b0;
    logic [1:0]  d_sum_msb = '0;
    logic        d_out_valid;
    logic [10:0] d_exp_out;
    logic        d_max_exp;
    logic        d_min_exp;
    logic [12:0] d_excess;
    logic        d_underflow;

`ifdef EXP_UPDATE_STICKY_EN
    logic sticky_ovf, sticky_unf;
    logic d_sticky_clr = 1'b0;
    logic d_sticky_ovf, d_sticky_unf;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    res_t exp_q[$];
    res_t held;
    logic held_ok = 1'b0;

    always #5 clk = ~clk;

    exp_update_pipe #(.EXP_W(8), .MAN_W(23), .SH_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exp_in(exp_in), .ovf(ovf), .ovf_rnd(ovf_rnd),
        .massive_shift_left(msl), .one_shift_left(osl), .sum_msb(sum_msb),
        .sum_zero(sum_zero), .eop(eop), .zero_d(zero_d), .frac_zero(frac_zero),
        .out_valid(out_valid), .out_ready(out_ready), .exp_out(exp_out),
        .max_exp(max_exp), .min_exp(min_exp), .excess_shift(excess_shift),
`ifdef EXP_UPDATE_STICKY_EN
        .sticky_clr(1'b0), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
`endif
        .underflow(underflow)
    );

    exp_update_pipe #(.EXP_W(11), .MAN_W(52), .SH_W(6)) dut_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .exp_in(d_exp_in), .ovf(d_ovf), .ovf_rnd(1'b0),
        .massive_shift_left(6'd0), .one_shift_left(1'b0), .sum_msb(d_sum_msb),
        .sum_zero(1'b0), .eop(1'b0), .zero_d(1'b0), .frac_zero(1'b0),
        .out_valid(d_out_valid), .out_ready(1'b1), .exp_out(d_exp_out),
        .max_exp(d_max_exp), .min_exp(d_min_exp), .excess_shift(d_excess),
`ifdef EXP_UPDATE_STICKY_EN
        .sticky_clr(d_sticky_clr), .sticky_ovf(d_sticky_ovf), .sticky_unf(d_sticky_unf),
`endif
        .underflow(d_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on each output transfer; while stalled the
    // presented result must not change.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            res_t got;
            got = '{e: exp_out, mx: max_exp, mn: min_exp, xs: excess_shift, uf: underflow};
            if (out_ready) begin
                held_ok = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(got), 32'h0);
                    if (got == '0) begin
                        n_bad++;
                        $display("FAIL unexpected_output: got valid result expected none");
                    end
                end else begin
                    res_t req;
                    req = exp_q.pop_front();
                    check("result", 32'(got), 32'(req));
                    $display("out exp=%0d max=%0b min=%0b excess=%0d unf=%0b", got.e, got.mx, got.mn, got.xs, got.uf);
                end
            end else begin
                if (held_ok) check("stall_stable", 32'(got), 32'(held));
                held = got;
                held_ok = 1'b1;
            end
        end else begin
            held_ok = 1'b0;
        end
    end

    task automatic send(input logic [7:0] ei, input logic ov, input logic orn,
                        input logic [4:0] ms, input logic os, input logic [1:0] sm,
                        input logic sz, input logic ep, input logic zd, input logic fz,
                        input logic [7:0] r_e, input logic r_mx, input logic r_mn,
                        input logic [9:0] r_xs, input logic r_uf);
        bit done;
        done = 1'b0;
        exp_in = ei; ovf = ov; ovf_rnd = orn; msl = ms; osl = os; sum_msb = sm;
        sum_zero = sz; eop = ep; zero_d = zd; frac_zero = fz;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back('{e: r_e, mx: r_mx, mn: r_mn, xs: r_xs, uf: r_uf});
                n_acc++;
                $display("in  exp_in=%0d ovf=%0b rnd=%0b msl=%0d osl=%0b msb=%02b", ei, ov, orn, ms, os, sm);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1");
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_outputs", {exp_out, max_exp, min_exp, excess_shift, underflow}, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Directed vectors: exp_in ovf rnd msl osl msb sz eop zd fz | expected
        send(8'd100, 0, 0, 5'd5, 0, 2'b00, 0, 0, 0, 0, 8'd95, 0, 0, 10'd0, 0);
        send(8'd254, 1, 0, 5'd0, 0, 2'b01, 0, 0, 0, 0, 8'hFF, 1, 0, 10'd0, 0);
        send(8'd3,   0, 0, 5'd10, 0, 2'b00, 0, 0, 0, 0, 8'd0, 0, 1, 10'd7, 1);
        send(8'd200, 0, 0, 5'd0, 0, 2'b01, 1, 1, 1, 0, 8'd0, 0, 1, 10'd0, 0);
        send(8'd1,   0, 0, 5'd0, 1, 2'b10, 0, 0, 0, 0, 8'd1, 0, 0, 10'd0, 0);
        send(8'd1,   0, 0, 5'd0, 1, 2'b01, 0, 0, 0, 0, 8'd0, 0, 1, 10'd0, 1);
        send(8'd1,   0, 0, 5'd0, 1, 2'b01, 0, 0, 0, 1, 8'd0, 0, 1, 10'd0, 0);
        send(8'd253, 0, 1, 5'd0, 0, 2'b10, 0, 0, 0, 0, 8'd254, 0, 0, 10'd0, 0);
        send(8'd254, 0, 1, 5'd0, 0, 2'b10, 0, 0, 0, 0, 8'hFF, 1, 0, 10'd0, 0);
        send(8'd10,  0, 0, 5'd10, 0, 2'b00, 0, 0, 0, 1, 8'd0, 0, 1, 10'd0, 0);
        send(8'd0,   0, 0, 5'd31, 0, 2'b00, 0, 0, 0, 0, 8'd0, 0, 1, 10'd31, 1);
        repeat (4) @(posedge clk); #1;

        // Backpressure: four back-to-back inputs against a stalled output.
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                send(8'd50, 0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 8'd50, 0, 0, 10'd0, 0);
                send(8'd60, 0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 8'd60, 0, 0, 10'd0, 0);
                send(8'd70, 0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 8'd70, 0, 0, 10'd0, 0);
                send(8'd80, 0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 8'd80, 0, 0, 10'd0, 0);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_accepts", 32'(n_acc), 2);
                check("bp_in_ready", 32'(in_ready), 0);
                check("bp_out_valid", 32'(out_valid), 1);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("bp_drained", 32'(exp_q.size()), 0);

`ifdef EXP_UPDATE_STICKY_EN
        @(negedge clk);
        check("sticky_unf_sp", 32'(sticky_unf), 1);
        check("sticky_ovf_sp", 32'(sticky_ovf), 1);
        @(posedge clk); #1;
`endif

        // Reset pulse mid-stream discards in-flight data.
        send(8'd20, 0, 0, 5'd0, 0, 2'b00, 0, 0, 0, 0, 8'd20, 0, 0, 10'd0, 0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 0);
        check("post_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Double-precision instance: 2046 + carry-out saturates.
        d_exp_in = 11'd2046; d_ovf = 1'b1; d_sum_msb = 2'b01; d_in_valid = 1'b1;
        @(negedge clk);
        check("d_in_ready", 32'(d_in_ready), 1);
        @(posedge clk); #1 d_in_valid = 1'b0;
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                @(negedge clk);
                if (d_out_valid) seen = 1'b1;
            end
            check("d_out_valid", 32'(seen), 1);
            $display("dp  exp_out=%0h max=%0b min=%0b unf=%0b", d_exp_out, d_max_exp, d_min_exp, d_underflow);
            check("d_exp_out", 32'(d_exp_out), 32'h7FF);
            check("d_flags", {d_max_exp, d_min_exp, d_underflow}, 3'b100);
            check("d_excess", 32'(d_excess), 0);
        end
`ifdef EXP_UPDATE_STICKY_EN
        @(negedge clk);
        check("d_sticky_set", 32'(d_sticky_ovf), 1);
        repeat (3) @(negedge clk);
        check("d_sticky_hold", 32'(d_sticky_ovf), 1);
        @(posedge clk); #1 d_sticky_clr = 1'b1;
        @(posedge clk); #1 d_sticky_clr = 1'b0;
        @(negedge clk);
        check("d_sticky_clr", 32'(d_sticky_ovf), 0);
`endif
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
